// File: rtl/host_uart_tx_arb_pkg.sv
// Shared definitions for the host UART transmit arbiter and its helpers.
// Holds the FSM encoding and the default channel-header base.
package host_uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } tx_arb_state_e;

   localparam logic [7:0] HDR_BASE_DEF = 8'hA0;

endpackage

// File: rtl/host_uart_rr_pick.sv
// Combinational cyclic priority search: first set req bit after index 'last',
// wrapping around; 'last' itself is checked at lowest priority.
module host_uart_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic               valid,
   output logic [ID_W-1:0]    idx
);

   always_comb begin
      valid = |req;
      idx   = '0;
      // Walk from the farthest candidate back to the nearest so the nearest wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (req[(int'(last) + k) % NUM_REQ])
            idx = ID_W'((int'(last) + k) % NUM_REQ);
      end
   end

endmodule

// File: rtl/host_uart_tx_arb.sv
// Packet-granular round-robin arbiter feeding one UART tx FWFT port from
// NUM_REQ FWFT requesters, prefixing each packet with a channel header byte.
module host_uart_tx_arb
   import host_uart_tx_arb_pkg::*;
#(
   parameter int         NUM_REQ     = 4,
   parameter int         ID_W        = 2,
   parameter logic [7:0] HDR_BASE    = HDR_BASE_DEF,
   parameter int         TIMEOUT_CYC = 1024,
   parameter int         CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_REQ-1:0]   req_empty,
   input  logic [NUM_REQ*8-1:0] req_dout,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_rd_en,
   input  logic                 uart_fifo_rd_en,
   output logic [7:0]           uart_fifo_dout,
   output logic                 uart_fifo_empty,
   output logic                 busy,
   output logic [ID_W-1:0]      cur_id,
   output logic                 pkt_done,
   output logic                 abort,
   output logic [CNT_W-1:0]     pkt_cnt,
   output logic [CNT_W-1:0]     abort_cnt
);

   localparam int TW = $clog2(TIMEOUT_CYC);

   tx_arb_state_e   state, state_nx;
   logic [ID_W-1:0] gnt, last_gnt, pick_idx;
   logic            pick_vld;
   logic [TW-1:0]   timer;
   logic            sel_empty, timed_out;

   host_uart_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req   (~req_empty),
      .last  (last_gnt),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   assign sel_empty = req_empty[gnt];
   assign timed_out = sel_empty && (timer == TW'(TIMEOUT_CYC - 1));
   assign busy      = (state != ST_IDLE);
   assign cur_id    = gnt;

   always_comb begin
      state_nx        = state;
      uart_fifo_empty = 1'b1;
      uart_fifo_dout  = HDR_BASE | {{(8-ID_W){1'b0}}, gnt};
      req_rd_en       = '0;
      pkt_done        = 1'b0;
      abort           = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable && pick_vld) state_nx = ST_HDR;
         end
         ST_HDR: begin
            uart_fifo_empty = 1'b0;
            if (uart_fifo_rd_en) state_nx = ST_DATA;
         end
         ST_DATA: begin
            uart_fifo_empty = sel_empty;
            uart_fifo_dout  = req_dout[{gnt, 3'b000} +: 8];
            req_rd_en[gnt]  = uart_fifo_rd_en & ~sel_empty;
            if (uart_fifo_rd_en && !sel_empty && req_last[gnt]) begin
               pkt_done = 1'b1;
               state_nx = ST_IDLE;
            end else if (timed_out) begin
               // Stalled mid-packet: drop the rest so other channels can proceed.
               abort    = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         gnt       <= '0;
         last_gnt  <= ID_W'(NUM_REQ - 1);
         timer     <= '0;
         pkt_cnt   <= '0;
         abort_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && enable && pick_vld) gnt <= pick_idx;
         if (state == ST_HDR && uart_fifo_rd_en) timer <= '0;
         if (state == ST_DATA) timer <= sel_empty ? timer + 1'b1 : '0;
         if (pkt_done || abort) last_gnt <= gnt;
         if (pkt_done) pkt_cnt <= pkt_cnt + 1'b1;
         if (abort) abort_cnt <= abort_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_host_uart_tx_arb.sv
// Directed bench for host_uart_tx_arb: FWFT requester models, a UART-side
// byte logger, and immediate-assertion checks against hand-derived streams.
module tb_host_uart_tx_arb;

   localparam int NR = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [NR-1:0] req_empty;
   logic [NR*8-1:0] req_dout;
   logic [NR-1:0] req_last;
   logic [NR-1:0] req_rd_en;
   logic          uart_fifo_rd_en;
   logic [7:0]    uart_fifo_dout;
   logic          uart_fifo_empty;
   logic          busy;
   logic [1:0]    cur_id;
   logic          pkt_done;
   logic          abort;
   logic [2:0]    pkt_cnt;
   logic [2:0]    abort_cnt;

   host_uart_tx_arb #(
      .NUM_REQ(NR), .ID_W(2), .HDR_BASE(8'hA0), .TIMEOUT_CYC(16), .CNT_W(3)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req_empty(req_empty), .req_dout(req_dout), .req_last(req_last),
      .req_rd_en(req_rd_en), .uart_fifo_rd_en(uart_fifo_rd_en),
      .uart_fifo_dout(uart_fifo_dout), .uart_fifo_empty(uart_fifo_empty),
      .busy(busy), .cur_id(cur_id), .pkt_done(pkt_done), .abort(abort),
      .pkt_cnt(pkt_cnt), .abort_cnt(abort_cnt)
   );

   always #5 clk = ~clk;

   // Requester FWFT models: {last, byte} entries, head advanced by req_rd_en.
   logic [8:0] mem [NR][64];
   int head [NR];
   int tail [NR];

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         req_empty[i]        = (head[i] == tail[i]);
         req_dout[8*i +: 8]  = mem[i][head[i] % 64][7:0];
         req_last[i]         = mem[i][head[i] % 64][8];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NR; i++)
         if (req_rd_en[i]) head[i] <= head[i] + 1;
   end

   // UART-side monitor.
   logic [7:0] log_q[$];
   int cyc = 0, last_pop_cyc = 0, abort_gap = 0;
   int done_cnt = 0, abort_pulses = 0, rd2 = 0, rd3 = 0, viol = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         if (uart_fifo_rd_en && !uart_fifo_empty) begin
            log_q.push_back(uart_fifo_dout);
            last_pop_cyc <= cyc;
         end
         if (pkt_done) done_cnt <= done_cnt + 1;
         if (abort) begin
            abort_pulses <= abort_pulses + 1;
            abort_gap    <= cyc - last_pop_cyc;
         end
         if (req_rd_en[2]) rd2 <= rd2 + 1;
         if (req_rd_en[3]) rd3 <= rd3 + 1;
         for (int i = 0; i < NR; i++)
            if (req_rd_en[i] && !(uart_fifo_rd_en && !req_empty[i] && int'(cur_id) == i))
               viol <= viol + 1;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int i, input logic [7:0] b, input logic l);
      mem[i][tail[i] % 64] = {l, b};
      tail[i]++;
   endtask

   task automatic wait_log(input string tag, input int n, input int max_cyc);
      int k;
      k = 0;
      while (log_q.size() < n && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      if (log_q.size() < n) chk({tag, "_timeout"}, 32'(log_q.size()), 32'(n));
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic chk_log(input string tag, input logic [7:0] e[$]);
      chk({tag, "_len"}, 32'(log_q.size()), 32'(e.size()));
      for (int i = 0; i < e.size(); i++)
         if (i < log_q.size()) chk($sformatf("%s_b%0d", tag, i), 32'(log_q[i]), 32'(e[i]));
   endtask

   initial begin
      logic [7:0] e[$];
      reset = 1'b1; enable = 1'b0; uart_fifo_rd_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_empty", 32'(uart_fifo_empty), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cur_id", 32'(cur_id), 32'd0);
      chk("rst_rd_en", 32'(req_rd_en), 32'd0);
      chk("rst_cnts", {26'd0, pkt_cnt, abort_cnt}, 32'd0);
      chk("rst_pulses", {30'd0, pkt_done, abort}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // T1: single requester, two-byte packet.
      enable = 1'b1; uart_fifo_rd_en = 1'b1;
      push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b1);
      wait_log("t1", 3, 40);
      wait_idle("t1", 20);
      e = '{8'hA2, 8'h11, 8'h22};
      chk_log("t1", e);
      chk("t1_done", 32'(done_cnt), 32'd1);
      chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);
      chk("t1_rd2", 32'(rd2), 32'd2);

      // T2: three 1-byte packets; last grant was 2 so the search starts at 3.
      enable = 1'b0; log_q.delete();
      push(0, 8'h55, 1'b1); push(1, 8'h55, 1'b1); push(3, 8'h55, 1'b1);
      @(negedge clk);
      chk("t2_no_grant", 32'(busy), 32'd0);
      enable = 1'b1;
      wait_log("t2", 6, 60);
      wait_idle("t2", 20);
      e = '{8'hA3, 8'h55, 8'hA0, 8'h55, 8'hA1, 8'h55};
      chk_log("t2", e);
      chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd4);

      // T3: req 0 keeps packets queued, req 1 has one; req 1 must not be starved.
      enable = 1'b0; log_q.delete();
      push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1); push(0, 8'h03, 1'b1);
      push(1, 8'h77, 1'b1);
      enable = 1'b1;
      wait_log("t3", 8, 80);
      wait_idle("t3", 20);
      e = '{8'hA0, 8'h01, 8'hA1, 8'h77, 8'hA0, 8'h02, 8'hA0, 8'h03};
      chk_log("t3", e);
      chk("t3_pkt_cnt_wrap", 32'(pkt_cnt), 32'd0);

      // T4: req 1 stalls mid-packet; abort after 16 empty cycles, then req 2.
      enable = 1'b0; log_q.delete();
      push(1, 8'h31, 1'b0); push(2, 8'h42, 1'b1);
      enable = 1'b1;
      wait_log("t4a", 2, 20);
      chk("t4_busy_stall", 32'(busy), 32'd1);
      wait_log("t4b", 4, 60);
      wait_idle("t4", 20);
      e = '{8'hA1, 8'h31, 8'hA2, 8'h42};
      chk_log("t4", e);
      chk("t4_abort_pulses", 32'(abort_pulses), 32'd1);
      chk("t4_abort_gap", 32'(abort_gap), 32'd16);
      chk("t4_abort_cnt", 32'(abort_cnt), 32'd1);
      chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd1);

      // T5: UART pops every third cycle, including while the source is empty.
      log_q.delete();
      push(3, 8'h61, 1'b0);
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         uart_fifo_rd_en = (k % 3 == 0);
         if (k == 12) push(3, 8'h62, 1'b1);
      end
      uart_fifo_rd_en = 1'b1;
      wait_idle("t5", 20);
      e = '{8'hA3, 8'h61, 8'h62};
      chk_log("t5", e);
      chk("t5_rd3", 32'(rd3), 32'd3);
      chk("t5_viol", 32'(viol), 32'd0);
      chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd2);

      // T6: asynchronous reset in DATA after the first of three bytes.
      log_q.delete();
      push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b0); push(0, 8'h73, 1'b1);
      wait_log("t6", 2, 20);
      enable = 1'b0;
      reset = 1'b1;
      #1;
      chk("t6_async_empty", 32'(uart_fifo_empty), 32'd1);
      chk("t6_async_busy", 32'(busy), 32'd0);
      chk("t6_async_rd_en", 32'(req_rd_en), 32'd0);
      chk("t6_async_cnts", {26'd0, pkt_cnt, abort_cnt}, 32'd0);
      chk("t6_async_cur_id", 32'(cur_id), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      chk("t6_no_grant", 32'(busy), 32'd0);
      chk("t6_log_frozen", 32'(log_q.size()), 32'd2);
      enable = 1'b1;
      wait_log("t6r", 5, 30);
      wait_idle("t6", 20);
      e = '{8'hA0, 8'h71, 8'hA0, 8'h72, 8'h73};
      chk_log("t6", e);
      chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);
      chk("t6_viol", 32'(viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/host_uart_tx_arb.md
Name: host_uart_tx_arb

Overview:
Round-robin, packet-granular arbiter that shares the single host UART transmit path between NUM_REQ byte-stream requesters.
- Each requester exposes a first-word-fall-through (FWFT) FIFO read port with a last-byte flag.
- The block prefixes each granted packet with a one-byte channel header.
- It presents a single FWFT FIFO read port to the UART transmitter's tx FIFO interface.
- A mid-packet starvation timeout aborts stalled packets so other channels are not locked out.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of channel index, clog2(NUM_REQ)
HDR_BASE, 8'hA0, header byte = HDR_BASE | channel index (low bits of HDR_BASE must be zero)
TIMEOUT_CYC, 1024, consecutive empty cycles mid-packet before abort (>=2)
CNT_W, 16, width of status counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = new packets may be granted; 0 lets the current packet finish, then no new grants
req_empty  in  NUM_REQ  per-requester FIFO empty
req_dout  in  NUM_REQ*8  per-requester FWFT data; requester i at bits [8i+7:8i]
req_last  in  NUM_REQ  per-requester: current req_dout byte is the last of its packet
req_rd_en  out  NUM_REQ  per-requester pop strobe
uart_fifo_rd_en  in  1  pop strobe from UART tx
uart_fifo_dout  out  8  FWFT byte to UART tx
uart_fifo_empty  out  1  no byte available to UART tx
busy  out  1  state != IDLE
cur_id  out  ID_W  currently granted channel
pkt_done  out  1  one-cycle pulse when last byte of a packet is popped
abort  out  1  one-cycle pulse on timeout abort
pkt_cnt  out  CNT_W  completed packets, wraps
abort_cnt  out  CNT_W  aborted packets, wraps

Behaviour:
Reset (async, any time, including mid-packet):
- state=IDLE, gnt=0, last_gnt=NUM_REQ-1, timer=0.
- pkt_cnt=0, abort_cnt=0, pkt_done=0, abort=0.
- uart_fifo_empty=1, req_rd_en=0, busy=0, cur_id=0.
- A packet interrupted by reset is not resumed; any partial bytes already sent are lost.

States: IDLE, HDR, DATA.

IDLE:
- Forces uart_fifo_empty=1.
- If enable=1 and any req_empty[i]=0, register gnt = first non-empty index searching cyclically from last_gnt+1.
- Then go to HDR; this costs one cycle, so there is no combinational path from req_empty to the grant.

HDR:
- uart_fifo_empty=0, uart_fifo_dout=HDR_BASE|gnt.
- On uart_fifo_rd_en=1, go to DATA and clear timer.

DATA:
- uart_fifo_empty=req_empty[gnt], uart_fifo_dout=req_dout[gnt].
- req_rd_en[gnt]=uart_fifo_rd_en & ~req_empty[gnt] (combinational); all other req_rd_en bits are 0.
- On pop with req_last[gnt]=1: pulse pkt_done, pkt_cnt+1, last_gnt=gnt, go to IDLE.
- Timer counts cycles with req_empty[gnt]=1 and clears on any non-empty cycle.
- When timer reaches TIMEOUT_CYC-1 while still empty: pulse abort, abort_cnt+1, last_gnt=gnt, go to IDLE.
- No byte is popped on the abort cycle.

Boundary and ordering rules:
- uart_fifo_rd_en while uart_fifo_empty=1 is ignored: no pop, no state change.
- Single-byte packet (last set on the first byte): sequence is HDR, one data byte, IDLE. Minimum packet cost is 3 cycles including IDLE.
- enable is sampled only in IDLE. Deasserting it mid-packet does not truncate the packet.
- req_last is honoured only on a pop cycle.
- Counters wrap from all-ones to 0.
- cur_id=gnt in all states.

Fairness: a continuously requesting channel is served at most once per NUM_REQ grants while others wait.

Decomposition:
- Shared package/define file (alongside the existing UART defines) holds:
  - state encodings ST_IDLE=2'd0, ST_HDR=2'd1, ST_DATA=2'd2
  - default HDR_BASE
- One sub-module: host_uart_rr_pick. It is a combinational cyclic priority search over the request vector, with inputs req[NUM_REQ] and last[ID_W] and outputs valid and idx[ID_W]. It is reusable for the RX-side demux.

Test Plan:
- Only req 2 holds [0x11,0x22(last)], UART pops every cycle -> UART sees 0xA2,0x11,0x22; one pkt_done pulse; pkt_cnt=1; req_rd_en[2] high on exactly 2 cycles.
- Reqs 0,1,3 all hold 1-byte packets 0x55(last) -> headers in order 0xA0,0xA1,0xA3, each followed by 0x55; pkt_cnt=3.
- Req 0 refills continuously with 1-byte packets; req 1 has one packet -> order 0xA0,…,0xA1,…,0xA0: req 1 is served after at most one req-0 packet.
- Req 1 sends one byte (not last), then stays empty for TIMEOUT_CYC=16 cycles -> abort pulses on the 16th empty cycle; abort_cnt=1; state IDLE; a pending req 2 is granted next (0xA2).
- UART asserts rd_en every 3rd cycle, including while empty -> no pops while empty; byte stream unchanged; req_rd_en only when non-empty and rd_en=1.
- Reset asserted in DATA after 1 of 3 bytes, with enable=0 before the next packet -> all outputs at reset values asynchronously; after release, no grant until enable=1; pkt_cnt=0.
